// File: rtl/aes_pkg.sv
// Shared types and constants for the iterative AES round sequencer.
// Round counts per key size, the block type and the controller state encoding.
`timescale 1ns/1ps
package aes_pkg;

    localparam int AES_NR_128 = 10;
    localparam int AES_NR_192 = 12;
    localparam int AES_NR_256 = 14;

    typedef logic [127:0] aes_block_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } aes_state_e;

endpackage

// File: rtl/aes_round_ctrl.sv
// Iterative AES round sequencer: owns the state register and round counter,
// steps an external round datapath once per cycle with keys fetched by index.
`timescale 1ns/1ps
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR = AES_NR_256,
    localparam int RW = $clog2(NR + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [127:0]  in_data_i,
    output logic [RW-1:0] rk_idx_o,
    input  logic [127:0]  rk_i,
    input  logic          rk_valid_i,
    output logic [127:0]  dp_state_o,
    output logic          dp_last_o,
    input  logic [127:0]  dp_result_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [127:0]  out_data_o,
    output logic          busy_o
);

    localparam logic [RW-1:0] LP_NR  = RW'(NR);
    localparam logic [RW-1:0] LP_ONE = RW'(1);

    aes_state_e    r_fsm;
    logic [RW-1:0] r_round;
    aes_block_t    r_state;

    logic w_idle;
    logic w_accept;
    logic w_step;
    logic w_drain;
    logic w_final;

    assign w_idle   = (r_fsm == IDLE);
    assign w_accept = w_idle && in_valid_i && rk_valid_i;
    assign w_step   = (r_fsm == ROUND) && rk_valid_i;
    assign w_drain  = (r_fsm == DONE) && out_ready_i;
    assign w_final  = (r_fsm == ROUND) && (r_round == LP_NR);

    // Counter saturates at NR on the last round; it is cleared on leaving DONE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_fsm   <= IDLE;
            r_round <= '0;
            r_state <= '0;
        end else begin
            unique case (r_fsm)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= in_data_i ^ rk_i;
                        r_round <= LP_ONE;
                        r_fsm   <= ROUND;
                    end
                end
                ROUND: begin
                    if (w_step) begin
                        r_state <= dp_result_i;
                        if (w_final) begin
                            r_fsm <= DONE;
                        end else begin
                            r_round <= r_round + LP_ONE;
                        end
                    end
                end
                DONE: begin
                    if (w_drain) begin
                        r_fsm   <= IDLE;
                        r_round <= '0;
                    end
                end
                default: begin
                    r_fsm   <= IDLE;
                    r_round <= '0;
                end
            endcase
        end
    end

    assign in_ready_o  = w_idle && rk_valid_i;
    assign rk_idx_o    = r_round;
    assign dp_state_o  = r_state;
    assign dp_last_o   = w_final;
    assign out_valid_o = (r_fsm == DONE);
    assign out_data_o  = r_state;
    assign busy_o      = !w_idle;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: behavioural AES round/key schedule plus a mock
// datapath, scoreboard-checked outputs, directed timing cases and random blocks.
`timescale 1ns/1ps
module tb_aes_round_ctrl;
    import aes_pkg::*;

    localparam int NR   = 14;
    localparam int RW   = $clog2(NR + 1);
    localparam int RW10 = $clog2(11);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          rst_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic [127:0]  in_data_i;
    logic [RW-1:0] rk_idx_o;
    logic [127:0]  rk_i;
    logic          rk_valid_i;
    logic [127:0]  dp_state_o;
    logic          dp_last_o;
    logic [127:0]  dp_result_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [127:0]  out_data_o;
    logic          busy_o;

    logic            in_valid10;
    logic            in_ready10;
    logic [127:0]    in_data10;
    logic [RW10-1:0] rk_idx10;
    logic [127:0]    rk10;
    logic            rk_valid10;
    logic [127:0]    dp_state10;
    logic            dp_last10;
    logic [127:0]    dp_result10;
    logic            out_valid10;
    logic            out_ready10;
    logic [127:0]    out_data10;
    logic            busy10;

    logic [7:0]   sbox [256];
    logic [127:0] ks14 [0:14];
    logic [127:0] ks10 [0:10];
    logic         mock;
    logic         rnd;

    typedef struct {
        logic [127:0] data;
        int           due;
    } exp_t;
    exp_t sb [$];

    int n_chk  = 0;
    int n_fail = 0;

    aes_round_ctrl #(.NR(NR)) u_dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .rk_idx_o    (rk_idx_o),
        .rk_i        (rk_i),
        .rk_valid_i  (rk_valid_i),
        .dp_state_o  (dp_state_o),
        .dp_last_o   (dp_last_o),
        .dp_result_i (dp_result_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .busy_o      (busy_o)
    );

    aes_round_ctrl #(.NR(AES_NR_128)) u_dut10 (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid10),
        .in_ready_o  (in_ready10),
        .in_data_i   (in_data10),
        .rk_idx_o    (rk_idx10),
        .rk_i        (rk10),
        .rk_valid_i  (rk_valid10),
        .dp_state_o  (dp_state10),
        .dp_last_o   (dp_last10),
        .dp_result_i (dp_result10),
        .out_valid_o (out_valid10),
        .out_ready_i (out_ready10),
        .out_data_o  (out_data10),
        .busy_o      (busy10)
    );

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_round(input logic [127:0] s,
                                               input logic [127:0] k,
                                               input logic last);
        logic [7:0] a [16];
        logic [7:0] b [16];
        logic [7:0] m0, m1, m2, m3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) a[i] = sbox[s[127-8*i -: 8]];
        // byte index = 4*column + row; row r rotates left by r columns
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++)
                b[4*c+rr] = a[4*((c+rr)%4)+rr];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                m0 = b[4*c]; m1 = b[4*c+1]; m2 = b[4*c+2]; m3 = b[4*c+3];
                b[4*c]   = gmul(8'h02, m0) ^ gmul(8'h03, m1) ^ m2 ^ m3;
                b[4*c+1] = m0 ^ gmul(8'h02, m1) ^ gmul(8'h03, m2) ^ m3;
                b[4*c+2] = m0 ^ m1 ^ gmul(8'h02, m2) ^ gmul(8'h03, m3);
                b[4*c+3] = gmul(8'h03, m0) ^ m1 ^ m2 ^ gmul(8'h02, m3);
            end
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
        return r ^ k;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    task automatic expand(input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nr;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) begin
            if (nr == 14) ks14[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else if (r <= 10) ks10[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endtask

    function automatic logic [127:0] ref_enc(input logic [127:0] pt, input logic m);
        logic [127:0] s;
        s = pt ^ ks14[0];
        if (m) return s + 128'(NR);
        for (int r = 1; r <= NR; r++) s = aes_round(s, ks14[r], r == NR);
        return s;
    endfunction

    assign rk_i        = ks14[rk_idx_o];
    assign dp_result_i = mock ? dp_state_o + 128'd1
                              : aes_round(dp_state_o, rk_i, dp_last_o);
    assign rk10        = ks10[rk_idx10];
    assign dp_result10 = aes_round(dp_state10, rk10, dp_last10);

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (rnd) begin
            rk_valid_i  = ($urandom_range(0, 3) != 0);
            out_ready_i = ($urandom_range(0, 2) != 0);
        end
    endtask

    task automatic send(input logic [127:0] pt, input int extra,
                        input bit keep, output int t_acc);
        exp_t e;
        in_data_i  = pt;
        in_valid_i = 1'b1;
        t_acc = -1;
        for (int k = 0; k < 400; k++) begin
            #1;
            if (in_ready_o) begin
                t_acc  = cyc;
                e.data = ref_enc(pt, mock);
                e.due  = (extra < 0) ? -1 : cyc + NR + 1 + extra;
                sb.push_back(e);
                break;
            end
            tick();
        end
        if (t_acc < 0) check("accept_timeout", 128'd0, 128'd1);
        tick();
        if (!keep) in_valid_i = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 400 && sb.size() != 0; k++) tick();
        if (sb.size() != 0) begin
            check("drain_timeout", 128'(sb.size()), 128'd0);
            sb.delete();
        end
        tick();
    endtask

    // Monitor: checks every presented output against the queue head.
    initial begin
        bit seen;
        seen = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_i && out_valid_o) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 128'd1, 128'd0);
                end else begin
                    check("out_data", out_data_o, sb[0].data);
                    if (!seen && sb[0].due >= 0)
                        check("out_latency", 128'(cyc), 128'(sb[0].due));
                    seen = 1'b1;
                    if (out_ready_i) begin
                        void'(sb.pop_front());
                        seen = 1'b0;
                    end
                end
            end
            if (!rst_i && dp_last_o) check("dp_last_idx", 128'(rk_idx_o), 128'(NR));
            if (!rst_i && dp_last10) check("dp_last10_idx", 128'(rk_idx10), 128'd10);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1);
    end

    initial begin
        int t, ta, tb;
        logic [255:0] key;
        build_sbox();
        rnd = 1'b0; mock = 1'b0;
        rst_i = 1'b1; in_valid_i = 1'b0; in_data_i = '0;
        rk_valid_i = 1'b0; out_ready_i = 1'b1;
        in_valid10 = 1'b0; in_data10 = '0; rk_valid10 = 1'b1; out_ready10 = 1'b1;
        expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
        repeat (3) tick();
        #1;
        check("rst_in_ready_lo", 128'(in_ready_o), 128'd0);
        rk_valid_i = 1'b1;
        #1;
        check("rst_in_ready_hi", 128'(in_ready_o), 128'd1);
        check("rst_out_valid", 128'(out_valid_o), 128'd0);
        check("rst_busy", 128'(busy_o), 128'd0);
        check("rst_rk_idx", 128'(rk_idx_o), 128'd0);
        check("rst_dp_last", 128'(dp_last_o), 128'd0);
        check("rst_out_data", out_data_o, 128'd0);
        tick();
        rst_i = 1'b0;
        tick();

        // FIPS-197 C.3
        send(128'h00112233445566778899aabbccddeeff, 0, 1'b0, t);
        for (int k = 0; k < 40; k++) begin
            #1;
            if (cyc == t + NR - 1) check("c3_last_early", 128'(dp_last_o), 128'd0);
            if (cyc == t + NR) check("c3_last", 128'(dp_last_o), 128'd1);
            if (out_valid_o) break;
            tick();
        end
        check("c3_data", out_data_o, 128'h8ea2b7ca516745bfeafc49904b496089);
        check("c3_latency", 128'(cyc), 128'(t + NR + 1));
        drain();

        // mock datapath with a 3-cycle key stall at round 5
        mock = 1'b1;
        send(128'h0123456789abcdef0011223344556677, 3, 1'b0, t);
        for (int k = 0; k < 40; k++) begin
            #1;
            if (rk_idx_o == RW'(5)) break;
            tick();
        end
        rk_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_idx", 128'(rk_idx_o), 128'd5);
            tick();
        end
        rk_valid_i = 1'b1;
        drain();

        // consumer back-pressure in DONE
        mock = 1'b0;
        out_ready_i = 1'b0;
        send(128'hfedcba98765432100f1e2d3c4b5a6978, 0, 1'b0, t);
        for (int k = 0; k < 40 && !out_valid_o; k++) tick();
        for (int i = 0; i < 10; i++) begin
            #1;
            check("hold_in_ready", 128'(in_ready_o), 128'd0);
            check("hold_valid", 128'(out_valid_o), 128'd1);
            tick();
        end
        out_ready_i = 1'b1;
        tick();
        #1;
        check("release_in_ready", 128'(in_ready_o), 128'd1);
        check("release_busy", 128'(busy_o), 128'd0);
        drain();

        // back-to-back blocks with in_valid held high
        send(128'h11111111222222223333333344444444, 0, 1'b1, ta);
        send(128'h55555555666666667777777788888888, 0, 1'b0, tb);
        check("b2b_spacing", 128'(tb - ta), 128'(NR + 2));
        drain();

        // reset in the middle of a block
        send(128'hdeadbeefcafef00d0badc0de12345678, 0, 1'b0, t);
        for (int k = 0; k < 40; k++) begin
            #1;
            if (rk_idx_o == RW'(7)) break;
            tick();
        end
        rst_i = 1'b1;
        void'(sb.pop_back());
        tick();
        rst_i = 1'b0;
        #1;
        check("mid_rst_busy", 128'(busy_o), 128'd0);
        check("mid_rst_valid", 128'(out_valid_o), 128'd0);
        check("mid_rst_idx", 128'(rk_idx_o), 128'd0);
        check("mid_rst_data", out_data_o, 128'd0);
        tick();
        send(128'h00112233445566778899aabbccddeeff, 0, 1'b0, t);
        drain();

        // randomized blocks, keys, datapath mode, stalls and back-pressure
        rnd = 1'b1;
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                drain();
                for (int j = 0; j < 8; j++) key[255-32*j -: 32] = $urandom;
                expand(key, 8);
                mock = ($urandom_range(0, 1) == 1);
            end
            send({$urandom, $urandom, $urandom, $urandom}, -1, 1'b0, t);
            repeat ($urandom_range(0, 3)) tick();
        end
        drain();
        rnd = 1'b0;
        rk_valid_i = 1'b1;
        out_ready_i = 1'b1;

        // AES-128 build, FIPS-197 C.1
        expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
        in_data10  = 128'h00112233445566778899aabbccddeeff;
        in_valid10 = 1'b1;
        #1;
        t = cyc;
        check("c1_ready", 128'(in_ready10), 128'd1);
        tick();
        in_valid10 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (out_valid10) break;
            tick();
        end
        check("c1_data", out_data10, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        check("c1_latency", 128'(cyc), 128'(t + 11));
        tick();
        #1;
        check("c1_idle", 128'(busy10), 128'd0);
        check("sb_empty", 128'(sb.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
